// File: rtl/fifo_drain.sv
// Read-side drain for the dual-clock Fifo: issues reads, absorbs the one-cycle read latency and
// re-presents words as a valid/ready stream via a 2-entry skid buffer. Optional macro: FIFO_DRAIN_COUNT_EN.
module fifo_drain #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   readClk,
    input  logic                   readRst,
    input  logic                   fifoEmpty,
    output logic                   fifoRead,
    input  logic [WIDTH-1:0]       fifoData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [WIDTH-1:0]       outData
`ifdef FIFO_DRAIN_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] wordCount
`endif
);

    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]       occ_q, occ_d;
    logic             in_flight_q, in_flight_d;
    logic             out_valid_q, out_valid_d;
    logic             pop;
    logic             capture;
    logic [2:0]       pending;

    assign pop     = out_valid_q & outReady;
    assign capture = in_flight_q;

    // Words that will still occupy the buffer after this edge if no new read is issued.
    assign pending  = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
    assign fifoRead = ~readRst & ~fifoEmpty & (pending < 3'd2);

    assign outValid = out_valid_q;
    assign outData  = buf0_q;

    always_comb begin
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        occ_d       = occ_q;
        in_flight_d = fifoRead;
        unique case ({capture, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifoData;
                end else begin
                    buf1_d = fifoData;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Head leaves and a new word arrives in the same edge; occupancy is unchanged.
                if (occ_q == 2'd1) begin
                    buf0_d = fifoData;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifoData;
                end
            end
            default: begin
            end
        endcase
        out_valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge readClk) begin
        if (readRst) begin
            buf0_q      <= '0;
            buf1_q      <= '0;
            occ_q       <= 2'd0;
            in_flight_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            occ_q       <= occ_d;
            in_flight_q <= in_flight_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef FIFO_DRAIN_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (pop) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge readClk) begin
        if (readRst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign wordCount = count_q;
`endif

    a_no_read_when_empty : assert property (
        @(posedge readClk) disable iff (readRst) fifoEmpty |-> !fifoRead);

    a_never_overfill : assert property (
        @(posedge readClk) disable iff (readRst) ({1'b0, occ_q} + {2'b00, in_flight_q}) <= 3'd2);

    a_stall_stable : assert property (
        @(posedge readClk) disable iff (readRst)
        (outValid && !outReady) |=> (outValid && $stable(outData)));

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: behavioural Fifo model plus an in-order scoreboard.
module tb_fifo_drain;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          readClk = 1'b0;
    logic          readRst = 1'b1;
    logic          fifoEmpty = 1'b1;
    logic          fifoRead;
    logic [W-1:0]  fifoData = '0;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [W-1:0]  outData;
`ifdef FIFO_DRAIN_COUNT_EN
    logic [CW-1:0] wordCount;
`endif

    fifo_drain #(
        .WIDTH       (W),
        .COUNT_WIDTH (CW)
    ) dut (
        .readClk   (readClk),
        .readRst   (readRst),
        .fifoEmpty (fifoEmpty),
        .fifoRead  (fifoRead),
        .fifoData  (fifoData),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData)
`ifdef FIFO_DRAIN_COUNT_EN
        ,
        .wordCount (wordCount)
`endif
    );

    always #5 readClk = ~readClk;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rd_cnt, val_cnt, first_rd, last_rd, first_val, last_val, pop_cnt;
    int cnt_model = 0;
    logic         s_valid;
    logic [W-1:0] s_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; val_cnt = 0; pop_cnt = 0;
        first_rd = -1; last_rd = -1; first_val = -1; last_val = -1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One clock cycle: drive inputs after negedge, sample what the next posedge will see.
    task automatic step(input logic rdy, input logic rst);
        logic         rd, pop, empty;
        logic [W-1:0] nd;
        @(negedge readClk);
        readRst   = rst;
        outReady  = rdy;
        empty     = (fifo_q.size() == 0);
        fifoEmpty = empty;
        #1;
        rd      = fifoRead;
        pop     = outValid & outReady;
        s_valid = outValid;
        s_data  = outData;
        nd      = fifoData;
        if (rd && empty) check_eq("read_when_empty", {31'b0, rd}, 32'd0);
        if (rst) check_eq("read_in_reset", {31'b0, rd}, 32'd0);
        if (rd && !empty) begin
            nd = fifo_q.pop_front();
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (outValid === 1'b1 && !rst) begin
            val_cnt++;
            if (first_val < 0) first_val = cyc;
            last_val = cyc;
        end
        if (rst) begin
            cnt_model = 0;
        end else if (pop) begin
            pop_cnt++;
            cnt_model = (cnt_model + 1) % (1 << CW);
            if (exp_q.size() == 0) check_eq("extra_word", {24'b0, outData}, 32'hFFFF_FFFF);
            else check_eq("stream_data", {24'b0, outData}, {24'b0, exp_q.pop_front()});
        end
        @(posedge readClk);
        #1;
        fifoData = nd;
        cyc++;
    endtask

    initial begin
        clear_stats();
        // 1: reset held with a non-empty Fifo.
        fifo_q.push_back(8'hEE);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check_eq("rst_valid", {31'b0, s_valid}, 32'd0);
`ifdef FIFO_DRAIN_COUNT_EN
            check_eq("rst_count", {28'b0, wordCount}, 32'd0);
`endif
        end
        check_eq("rst_reads", rd_cnt, 0);
        fifo_q.delete();
        exp_q.delete();

        // 2: single word.
        clear_stats();
        push_word(8'hA5);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        check_eq("single_reads", rd_cnt, 1);
        check_eq("single_valid_cycles", val_cnt, 1);
        check_eq("single_latency", last_val - last_rd, 2);
`ifdef FIFO_DRAIN_COUNT_EN
        check_eq("single_count", {28'b0, wordCount}, 32'd1);
`endif

        // 3: full-rate burst.
        clear_stats();
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        check_eq("burst_reads", rd_cnt, 8);
        check_eq("burst_read_span", last_rd - first_rd, 7);
        check_eq("burst_valid_cycles", val_cnt, 8);
        check_eq("burst_out_span", last_val - first_val, 7);
        check_eq("burst_drained", exp_q.size(), 0);

        // 4: backpressure then release.
        clear_stats();
        for (int i = 0; i < 8; i++) push_word(W'(8'h10 + i));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            if (s_valid) check_eq("stall_hold", {24'b0, s_data}, 32'h10);
        end
        check_eq("stall_reads", rd_cnt, 2);
        check_eq("stall_valid", {31'b0, s_valid}, 32'd1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        check_eq("release_pops", pop_cnt, 8);
        check_eq("release_drained", exp_q.size(), 0);

        // 5: reset mid-burst, Fifo reset alongside.
        clear_stats();
        for (int i = 0; i < 8; i++) push_word(W'(8'h20 + i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        fifo_q.delete();
        exp_q.delete();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check_eq("post_rst_valid", {31'b0, s_valid}, 32'd0);
`ifdef FIFO_DRAIN_COUNT_EN
        check_eq("post_rst_count", {28'b0, wordCount}, 32'd0);
`endif
        push_word(8'h30);
        push_word(8'h31);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        check_eq("post_rst_drained", exp_q.size(), 0);

        // 6: 17 words through, counter wraps; mixed backpressure.
        step(1'b1, 1'b1);
        clear_stats();
        for (int i = 0; i < 17; i++) push_word(W'($urandom_range(0, 255)));
        for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 3) != 0), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        check_eq("wrap_pops", pop_cnt, 17);
        check_eq("wrap_drained", exp_q.size(), 0);
`ifdef FIFO_DRAIN_COUNT_EN
        check_eq("wrap_count", {28'b0, wordCount}, 32'(cnt_model));
        check_eq("wrap_count_one", {28'b0, wordCount}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
